mc_block_engine: RTL

//  Parametrised motion-compensation address engine for block-based concealment.

---
 rtl/mc_block_engine.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mc_block_engine.sv
// Motion-compensation address engine: walks each BLKxBLK block, fetches its MV and emits
// write/reference pixel indices. Define MC_EDGE_CLAMP_EN to clamp reference coordinates to the frame edge.
module mc_block_engine #(
    parameter int unsigned BLK   = 4,
    parameter int unsigned DIM_W = 8,
    parameter int unsigned MV_W  = 8,
    parameter int unsigned IDX_W = 16
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DIM_W-1:0]        height,
    input  logic [DIM_W-1:0]        width,
    output logic [IDX_W-1:0]        mv_index,
    input  logic signed [MV_W-1:0]  mvx,
    input  logic signed [MV_W-1:0]  mvy,
    output logic                    we,
    input  logic                    ready,
    output logic [IDX_W-1:0]        out_index,
    output logic [IDX_W-1:0]        ref_index,
    output logic                    oob,
    output logic                    done
);
    localparam int unsigned LB = $clog2(BLK);
    localparam int unsigned CW = DIM_W + LB + 2;
    localparam int unsigned PW = 2 * CW;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, RUN, DONE} state_t;
    state_t state, state_n;

    logic [DIM_W-1:0]       h_r, w_r, bx, by, nbx, nby;
    logic [LB-1:0]          px, py, lpx, lpy;
    logic signed [MV_W-1:0] mvx_r, mvy_r, mvx_s, mvy_s;
    logic                   acc, last_pix, last_blk, load_pix;
    logic [CW-1:0]          x_c, y_c;
    logic signed [CW-1:0]   fw_c, fh_c, mvx_e, mvy_e, rx, ry;
    logic                   oob_c;
    logic [IDX_W-1:0]       out_c, ref_c, nbi_c;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and handshake decode
    always_comb begin
        state_n  = state;
        acc      = (state == RUN) && we && ready;
        last_pix = (px == LB'(BLK - 1)) && (py == LB'(BLK - 1));
        last_blk = (bx == w_r - DIM_W'(1)) && (by == h_r - DIM_W'(1));
        load_pix = (state == LOAD) || (acc && !last_pix);
        case (state)
            IDLE:  if (start) state_n = ((height == '0) || (width == '0)) ? DONE : FETCH;
            FETCH: state_n = LOAD;
            LOAD:  state_n = RUN;
            RUN:   if (acc && last_pix) state_n = last_blk ? DONE : FETCH;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Coordinates and indices of the pixel about to be presented
    always_comb begin
        if (state == LOAD) {lpy, lpx} = '0;
        else               {lpy, lpx} = {py, px} + (2 * LB)'(1);
        mvx_s = (state == LOAD) ? mvx : mvx_r;
        mvy_s = (state == LOAD) ? mvy : mvy_r;
        mvx_e = CW'(mvx_s);
        mvy_e = CW'(mvy_s);
        x_c   = CW'({bx, lpx});
        y_c   = CW'({by, lpy});
        fw_c  = CW'({w_r, LB'(0)});
        fh_c  = CW'({h_r, LB'(0)});
        rx    = $signed(x_c) - mvx_e;
        ry    = $signed(y_c) - mvy_e;
        oob_c = (rx < 0) || (ry < 0) || (rx >= fw_c) || (ry >= fh_c);
        out_c = IDX_W'(PW'(y_c) * PW'($unsigned(fw_c)) + PW'(x_c));
        ref_c = '0;
`ifdef MC_EDGE_CLAMP_EN
        begin
            logic [CW-1:0] rxc, ryc;
            rxc = (rx < 0) ? '0 : (rx >= fw_c) ? $unsigned(fw_c - CW'(1)) : $unsigned(rx);
            ryc = (ry < 0) ? '0 : (ry >= fh_c) ? $unsigned(fh_c - CW'(1)) : $unsigned(ry);
            ref_c = IDX_W'(PW'(ryc) * PW'($unsigned(fw_c)) + PW'(rxc));
        end
`else
        if (!oob_c)
            ref_c = IDX_W'(PW'($unsigned(ry)) * PW'($unsigned(fw_c)) + PW'($unsigned(rx)));
`endif
        nbx   = (bx == w_r - DIM_W'(1)) ? '0 : bx + DIM_W'(1);
        nby   = (bx == w_r - DIM_W'(1)) ? by + DIM_W'(1) : by;
        nbi_c = IDX_W'(PW'(nby) * PW'(w_r) + PW'(nbx));
    end

    // Registered datapath and outputs
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            h_r <= '0; w_r <= '0; bx <= '0; by <= '0; px <= '0; py <= '0;
            mvx_r <= '0; mvy_r <= '0;
            mv_index <= '0; out_index <= '0; ref_index <= '0;
            we <= 1'b0; oob <= 1'b0; done <= 1'b0;
        end else begin
            done <= (state_n == DONE);
            we   <= (state_n == RUN);
            if (state == IDLE && start) begin
                h_r <= height; w_r <= width;
                bx <= '0; by <= '0;
                mv_index <= '0;
            end
            if (state == LOAD) begin
                mvx_r <= mvx;
                mvy_r <= mvy;
            end
            if (load_pix) begin
                px <= lpx; py <= lpy;
                out_index <= out_c;
                ref_index <= ref_c;
                oob       <= oob_c;
            end
            if (acc && last_pix && !last_blk) begin
                bx <= nbx; by <= nby;
                mv_index <= nbi_c;
            end
        end
    end
endmodule
